ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
Multi-register transfer engine for LDM/STM. It sits between the multicycle controller, data memory and the register file, and acts as the initiator toward the register file. It walks a 16-bit register list and produces memory addresses, register read/write addresses and write enables, then handles base writeback. It owns the single regfile write port while busy; the controller must not assert its own regfile write during that time.

Parameters:
ADDR_W, 32, memory address and data width
LIST_W, 16, register list width (r0..r15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
is_load  in  1  1 = LDM, 0 = STM
up  in  1  ARM U bit: 1 = increment, 0 = decrement
pre  in  1  ARM P bit: 1 = before, 0 = after
wback  in  1  ARM W bit: write final address to base
base_reg  in  4  base register number Rn
base_addr  in  32  current Rn value
reg_list  in  16  register mask, bit i = ri
mem_req  out  1  memory access valid
mem_we  out  1  store strobe, qualified by mem_req
mem_addr  out  32  word address of current transfer
mem_wdata  out  32  store data, equals reg_rd
mem_rdata  in  32  load data
mem_ready  in  1  access completes this cycle
reg_ra  out  4  regfile read address (store source)
reg_rd  in  32  regfile read data (combinational)
reg_wa  out  4  regfile write address
reg_wd  out  32  regfile write data
reg_we  out  1  regfile write enable (r0..r14 only)
pc_we  out  1  load to r15: write PC
pc_wd  out  32  PC load value
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs are 0, and the internal list, counter and address are cleared. Reset mid-transfer aborts immediately with no further writes.
- States: IDLE -> SETUP -> XFER -> (WB) -> DONE -> IDLE.
- IDLE: if start=1, latch is_load, up, pre, wback, base_reg, base_addr and reg_list, then go to SETUP. start in any other state is ignored.
- SETUP (1 cycle): N = popcount(list), range 0..16, 5-bit. Start address is selected by {up, pre}:
  - IA: base
  - IB: base+4
  - DA: base-4N+4
  - DB: base-4N
- SETUP final value: base+4N if up, else base-4N. Arithmetic is mod 2^32.
- SETUP exit: N=0 goes to DONE directly, with no memory access and no writeback.
- XFER:
  - cur = lowest set bit of the remaining list.
  - Registers transfer in ascending order at ascending addresses, whatever the direction.
  - mem_req=1, mem_addr=current address, mem_we=~is_load, reg_ra=cur.
  - Outputs hold stable while mem_ready=0 (wait states, unbounded).
  - When mem_ready=1, the beat completes:
    - Load with cur<15: reg_we=1, reg_wa=cur, reg_wd=mem_rdata.
    - Load with cur=15: pc_we=1, pc_wd=mem_rdata, reg_we=0.
    - Then clear bit cur and add 4 to the address.
  - After the last bit, go to WB if wback=1 and the load-overlap rule below does not suppress it; otherwise go to DONE.
- Load overlap: if is_load and base_reg is in the list, writeback is suppressed and the loaded value wins.
- WB (1 cycle): reg_we=1, reg_wa=base_reg, reg_wd=final value. If base_reg=15, writeback is suppressed (transition skips WB).
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Write-port exclusivity: reg_we and pc_we are never both high, and at most one regfile write is issued per cycle.
- Latency with mem_ready tied to 1 and start at cycle 0:
  - SETUP at cycle 1.
  - Beats at cycles 2..N+1.
  - WB at N+2 if taken.
  - done at N+2, or at N+3 when WB is taken.

Test Plan:
- LDMIA: base_addr=0x100, list=0x000E, wback=1, base_reg=13, mem_ready=1.
  - Loads r1, r2, r3 from 0x100, 0x104, 0x108 with reg_we on cycles 2, 3, 4.
  - WB writes r13=0x10C on cycle 5; done on cycle 6.
- STMDB: base_addr=0x200, list=0x4010 (r4, r14), wback=1.
  - mem_addr=0x1F8 with reg_ra=4, then 0x1FC with reg_ra=14; mem_we=1 on both.
  - WB writes 0x1F8.
- Wait states: LDMIB, base_addr=0x40, list=0x0001, mem_ready low for 3 cycles.
  - mem_addr stays 0x44 and reg_we stays 0 for 3 cycles.
  - Single write of r0 when ready rises.
- r15 and overlap: LDMIA, base_reg=2, list=0x8004, wback=1.
  - r2 written from memory; pc_we=1 for r15; reg_we=0 on that beat.
  - No WB cycle.
- Empty list and abort:
  - list=0: no mem_req; done at cycle 2.
  - Separate run: reset_n=0 during beat 2 of a 4-register LDM; all outputs go 0 immediately and state is IDLE after release.
- Ignored start: pulse start while busy; the latched operation is unchanged and there is exactly one done.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM multi-register transfer engine: walks reg_list, drives memory + regfile, then base writeback.
// Latency: SETUP 1 cycle, one beat per register at mem_ready, optional WB cycle, then a 1-cycle done pulse.
// Backpressure: mem_ready=0 stalls the current beat indefinitely with all outputs held; start is ignored while busy.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       is_load,
  input  logic                       up,
  input  logic                       pre,
  input  logic                       wback,
  input  logic [$clog2(LIST_W)-1:0]  base_reg,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [LIST_W-1:0]          reg_list,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [ADDR_W-1:0]          mem_wdata,
  input  logic [ADDR_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic [$clog2(LIST_W)-1:0]  reg_ra,
  input  logic [ADDR_W-1:0]          reg_rd,
  output logic [$clog2(LIST_W)-1:0]  reg_wa,
  output logic [ADDR_W-1:0]          reg_wd,
  output logic                       reg_we,
  output logic                       pc_we,
  output logic [ADDR_W-1:0]          pc_wd,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(LIST_W);
  localparam int CNT_W = $clog2(LIST_W + 1);
  localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(LIST_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic              is_load_q;
  logic              up_q;
  logic              pre_q;
  logic              wback_q;
  logic              wb_en_q;
  logic [IDX_W-1:0]  base_reg_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] final_q;
  logic [LIST_W-1:0] list_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CNT_W-1:0]  n_set;
  logic [IDX_W-1:0]  cur;
  logic [ADDR_W-1:0] off4n;
  logic              xfer;
  logic              ld_beat;
  logic              pc_hit;
  logic              in_wb;

  always_comb begin
    n_set = '0;
    for (int i = 0; i < LIST_W; i++) n_set = n_set + CNT_W'(list_q[i]);
  end

  // Lowest set bit: ascending register order regardless of direction.
  always_comb begin
    cur = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list_q[i]) cur = IDX_W'(i);
    end
  end

  assign off4n = ADDR_W'({n_set, 2'b00});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      is_load_q  <= 1'b0;
      up_q       <= 1'b0;
      pre_q      <= 1'b0;
      wback_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      base_reg_q <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      list_q     <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            up_q       <= up;
            pre_q      <= pre;
            wback_q    <= wback;
            base_reg_q <= base_reg;
            base_q     <= base_addr;
            list_q     <= reg_list;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_q <= n_set;
          case ({up_q, pre_q})
            2'b10:   addr_q <= base_q;
            2'b11:   addr_q <= base_q + ADDR_W'(4);
            2'b00:   addr_q <= base_q - off4n + ADDR_W'(4);
            default: addr_q <= base_q - off4n;
          endcase
          final_q <= up_q ? (base_q + off4n) : (base_q - off4n);
          // A loaded base wins over writeback, and r15 is never a writeback target.
          wb_en_q <= wback_q && (base_reg_q != PC_IDX) && !(is_load_q && list_q[base_reg_q]);
          state   <= (n_set == '0) ? S_DONE : S_XFER;
        end
        S_XFER: begin
          if (mem_ready) begin
            list_q[cur] <= 1'b0;
            addr_q      <= addr_q + ADDR_W'(4);
            cnt_q       <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state <= wb_en_q ? S_WB : S_DONE;
          end
        end
        S_WB:    state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign xfer    = (state == S_XFER);
  assign in_wb   = (state == S_WB);
  assign ld_beat = xfer && mem_ready && is_load_q;
  assign pc_hit  = (cur == PC_IDX);

  assign mem_req   = xfer;
  assign mem_we    = xfer && !is_load_q;
  assign mem_addr  = xfer ? addr_q : '0;
  assign mem_wdata = mem_we ? reg_rd : '0;
  assign reg_ra    = xfer ? cur : '0;

  // The single write port is shared between load beats and base writeback.
  assign reg_we = (ld_beat && !pc_hit) || in_wb;
  assign reg_wa = in_wb ? base_reg_q : (reg_we ? cur : '0);
  assign reg_wd = in_wb ? final_q : (reg_we ? mem_rdata : '0);
  assign pc_we  = ld_beat && pc_hit;
  assign pc_wd  = pc_we ? mem_rdata : '0;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: per-cycle checks against hand-computed transfer schedules.
// Memory returns 0xD00D0000 ^ addr on loads; the regfile returns 0xCAFE0000 | ra on reads.
module tb_ldm_stm_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_load;
  logic        up;
  logic        pre;
  logic        wback;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [3:0]  reg_ra;
  logic [31:0] reg_rd;
  logic [3:0]  reg_wa;
  logic [31:0] reg_wd;
  logic        reg_we;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic        busy;
  logic        done;

  int total;
  int bad;

  ldm_stm_sequencer #(.ADDR_W(32), .LIST_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load), .up(up), .pre(pre),
    .wback(wback), .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .reg_ra(reg_ra), .reg_rd(reg_rd),
    .reg_wa(reg_wa), .reg_wd(reg_wd), .reg_we(reg_we), .pc_we(pc_we), .pc_wd(pc_wd),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = 32'hD00D0000 ^ mem_addr;
  assign reg_rd    = 32'hCAFE0000 | {28'd0, reg_ra};

  // Issue at posedge+1 in IDLE; returns at posedge+1 of cycle 1 with the inputs scrambled.
  task automatic start_op(input logic ld, input logic u, input logic p, input logic w,
                          input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list);
    start = 1'b1; is_load = ld; up = u; pre = p; wback = w;
    base_reg = rn; base_addr = base; reg_list = list;
    @(posedge clk); #1;
    start = 1'b0; is_load = ~ld; up = ~u; pre = ~p; wback = ~w;
    base_reg = 4'hF; base_addr = 32'hDEADBEE0; reg_list = 16'hFFFF;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, reg_ra, reg_wa, reg_wd, reg_we, pc_we, pc_wd, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got req=%0b we=%0b addr=%h rwe=%0b pcwe=%0b busy=%0b done=%0b want all 0",
               mem_req, mem_we, mem_addr, reg_we, pc_we, busy, done);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic test_ldmia();
    logic er, ewe, ed, eb;
    logic [31:0] ea, ewd;
    logic [3:0] ewa;
    mem_ready = 1'b1;
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h100, 16'h000E);
    for (int c = 1; c <= 7; c++) begin
      er = 0; ewe = 0; ed = 0; ea = 0; ewd = 0; ewa = 0; eb = (c <= 6);
      case (c)
        2, 3, 4: begin er = 1; ea = 32'h100 + 32'(4 * (c - 2)); ewe = 1; ewa = 4'(c - 1); ewd = 32'hD00D0000 ^ ea; end
        5: begin ewe = 1; ewa = 4'd13; ewd = 32'h10C; end
        6: ed = 1;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (mem_req !== er || mem_we !== 1'b0 || (er && mem_addr !== ea)) begin
        bad++;
        $display("FAIL ldmia_mem c%0d got req=%0b we=%0b addr=%h want req=%0b we=0 addr=%h", c, mem_req, mem_we, mem_addr, er, ea);
      end
      total++;
      if (reg_we !== ewe || (ewe && (reg_wa !== ewa || reg_wd !== ewd))) begin
        bad++;
        $display("FAIL ldmia_wr c%0d got we=%0b wa=%0d wd=%h want we=%0b wa=%0d wd=%h", c, reg_we, reg_wa, reg_wd, ewe, ewa, ewd);
      end
      total++;
      if (done !== ed || busy !== eb || pc_we !== 1'b0) begin
        bad++;
        $display("FAIL ldmia_ctl c%0d got done=%0b busy=%0b pcwe=%0b want done=%0b busy=%0b pcwe=0", c, done, busy, pc_we, ed, eb);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stmdb();
    logic er, ewe, ed, eb;
    logic [31:0] ea, ewd;
    logic [3:0] era, ewa;
    mem_ready = 1'b1;
    start_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h200, 16'h4010);
    for (int c = 1; c <= 6; c++) begin
      er = 0; ewe = 0; ed = 0; ea = 0; ewd = 0; ewa = 0; era = 0; eb = (c <= 5);
      case (c)
        2: begin er = 1; ea = 32'h1F8; era = 4'd4; end
        3: begin er = 1; ea = 32'h1FC; era = 4'd14; end
        4: begin ewe = 1; ewa = 4'd5; ewd = 32'h1F8; end
        5: ed = 1;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (mem_req !== er || mem_we !== er || (er && (mem_addr !== ea || reg_ra !== era))) begin
        bad++;
        $display("FAIL stmdb_mem c%0d got req=%0b we=%0b addr=%h ra=%0d want req=%0b we=%0b addr=%h ra=%0d",
                 c, mem_req, mem_we, mem_addr, reg_ra, er, er, ea, era);
      end
      total++;
      if (er && mem_wdata !== (32'hCAFE0000 | {28'd0, era})) begin
        bad++;
        $display("FAIL stmdb_wdata c%0d got %h want %h", c, mem_wdata, 32'hCAFE0000 | {28'd0, era});
      end
      total++;
      if (reg_we !== ewe || (ewe && (reg_wa !== ewa || reg_wd !== ewd)) || done !== ed || busy !== eb) begin
        bad++;
        $display("FAIL stmdb_wr c%0d got we=%0b wa=%0d wd=%h done=%0b busy=%0b want we=%0b wa=%0d wd=%h done=%0b busy=%0b",
                 c, reg_we, reg_wa, reg_wd, done, busy, ewe, ewa, ewd, ed, eb);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_states();
    logic er, ewe, ed;
    int nw;
    nw = 0;
    mem_ready = 1'b0;
    start_op(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 32'h40, 16'h0001);
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) mem_ready = 1'b1;
      er = (c >= 2 && c <= 5); ewe = (c == 5); ed = (c == 6);
      @(negedge clk);
      if (reg_we) nw++;
      total++;
      if (mem_req !== er || (er && mem_addr !== 32'h44)) begin
        bad++;
        $display("FAIL wait_mem c%0d got req=%0b addr=%h want req=%0b addr=00000044", c, mem_req, mem_addr, er);
      end
      total++;
      if (reg_we !== ewe || (ewe && (reg_wa !== 4'd0 || reg_wd !== 32'hD00D0044)) || done !== ed) begin
        bad++;
        $display("FAIL wait_wr c%0d got we=%0b wa=%0d wd=%h done=%0b want we=%0b wa=0 wd=d00d0044 done=%0b",
                 c, reg_we, reg_wa, reg_wd, done, ewe, ed);
      end
      @(posedge clk); #1;
    end
    total++;
    if (nw != 1) begin
      bad++;
      $display("FAIL wait_write_count got %0d want 1", nw);
    end
  endtask

  task automatic test_r15_overlap();
    logic ewe, epc, ed, eb;
    logic [31:0] ea;
    mem_ready = 1'b1;
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h300, 16'h8004);
    for (int c = 1; c <= 5; c++) begin
      ewe = (c == 2); epc = (c == 3); ed = (c == 4); eb = (c <= 4);
      ea = (c == 2) ? 32'h300 : 32'h304;
      @(negedge clk);
      total++;
      if (reg_we !== ewe || (ewe && (reg_wa !== 4'd2 || reg_wd !== 32'hD00D0300))) begin
        bad++;
        $display("FAIL r15_regwr c%0d got we=%0b wa=%0d wd=%h want we=%0b wa=2 wd=d00d0300", c, reg_we, reg_wa, reg_wd, ewe);
      end
      total++;
      if (pc_we !== epc || (epc && pc_wd !== 32'hD00D0304) || done !== ed || busy !== eb) begin
        bad++;
        $display("FAIL r15_pc c%0d got pcwe=%0b pcwd=%h done=%0b busy=%0b want pcwe=%0b pcwd=d00d0304 done=%0b busy=%0b",
                 c, pc_we, pc_wd, done, busy, epc, ed, eb);
      end
      if (c == 2 || c == 3) begin
        total++;
        if (mem_req !== 1'b1 || mem_addr !== ea) begin
          bad++;
          $display("FAIL r15_addr c%0d got req=%0b addr=%h want req=1 addr=%h", c, mem_req, mem_addr, ea);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_empty_list();
    logic ed, eb;
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h700, 16'h0000);
    for (int c = 1; c <= 3; c++) begin
      ed = (c == 2); eb = (c <= 2);
      @(negedge clk);
      total++;
      if (mem_req !== 1'b0 || reg_we !== 1'b0 || pc_we !== 1'b0 || done !== ed || busy !== eb) begin
        bad++;
        $display("FAIL empty c%0d got req=%0b rwe=%0b pcwe=%0b done=%0b busy=%0b want req=0 rwe=0 pcwe=0 done=%0b busy=%0b",
                 c, mem_req, reg_we, pc_we, done, busy, ed, eb);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    mem_ready = 1'b1;
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 32'h500, 16'h00F0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h504 || reg_we !== 1'b1 || reg_wa !== 4'd5) begin
      bad++;
      $display("FAIL abort_beat2 got req=%0b addr=%h we=%0b wa=%0d want req=1 addr=00000504 we=1 wa=5", mem_req, mem_addr, reg_we, reg_wa);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, reg_ra, reg_wa, reg_wd, reg_we, pc_we, pc_wd, busy, done} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got req=%0b addr=%h rwe=%0b wa=%0d busy=%0b done=%0b want all 0",
               mem_req, mem_addr, reg_we, reg_wa, busy, done);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || reg_we !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_idle c%0d got busy=%0b rwe=%0b req=%0b done=%0b want 0 0 0 0", c, busy, reg_we, mem_req, done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignored_start();
    logic er, ewe, ed;
    logic [31:0] ea, ewd;
    logic [3:0] ewa;
    int nd;
    nd = 0;
    mem_ready = 1'b1;
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h600, 16'h0006);
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin start = 1'b1; is_load = 1'b0; up = 1'b0; base_addr = 32'h900; reg_list = 16'hFFFF; end
      if (c == 3) start = 1'b0;
      er = 0; ewe = 0; ed = 0; ea = 0; ewd = 0; ewa = 0;
      case (c)
        2, 3: begin er = 1; ea = 32'h600 + 32'(4 * (c - 2)); ewe = 1; ewa = 4'(c - 1); ewd = 32'hD00D0000 ^ ea; end
        4: begin ewe = 1; ewa = 4'd9; ewd = 32'h608; end
        5: ed = 1;
        default: ;
      endcase
      @(negedge clk);
      if (done) nd++;
      total++;
      if (mem_req !== er || mem_we !== 1'b0 || (er && mem_addr !== ea)) begin
        bad++;
        $display("FAIL ignstart_mem c%0d got req=%0b we=%0b addr=%h want req=%0b we=0 addr=%h", c, mem_req, mem_we, mem_addr, er, ea);
      end
      total++;
      if (reg_we !== ewe || (ewe && (reg_wa !== ewa || reg_wd !== ewd)) || done !== ed) begin
        bad++;
        $display("FAIL ignstart_wr c%0d got we=%0b wa=%0d wd=%h done=%0b want we=%0b wa=%0d wd=%h done=%0b",
                 c, reg_we, reg_wa, reg_wd, done, ewe, ewa, ewd, ed);
      end
      @(posedge clk); #1;
    end
    total++;
    if (nd != 1) begin
      bad++;
      $display("FAIL ignstart_done_count got %0d want 1", nd);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
    base_reg = 4'd0; base_addr = 32'd0; reg_list = 16'd0; mem_ready = 1'b0;
    test_reset();
    test_ldmia();
    test_stmdb();
    test_wait_states();
    test_r15_overlap();
    test_empty_list();
    test_abort();
    test_ignored_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
